fb_port_arbiter: RTL

- Owns write/read port A of the RGB565 framebuffer BRAM: 15-bit cell address {row[6:0], col[7:0]}, 128 rows x 256 columns, 16-bit data. The display scan path reads port B.
- Shares port A between two requesters: the CPU bus (single-cell read/write) and an internal rectangle-fill engine (solid-colour clear/fill).
- Arbitration is alternating-priority, so neither requester starves under sustained contention.

---
 rtl/fb_port_arbiter_if.sv | 57 +++++
 rtl/fb_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port-A bus bundle: CPU single-cell access, fill-engine
// control and the BRAM port A pins. The arbiter sits on the slave side;
// requesters and the BRAM model sit on the master side.
//
// Handshake: cpu_req_i is raised with address/data/we stable and held
// until cpu_gnt_o is seen high in the same cycle; a grant means the access
// is on port A that cycle. Reads return cpu_rvalid_o/cpu_rdata_o exactly
// one cycle after their grant. fill_start_i is a one-cycle pulse that is
// only honoured while the fill engine is idle.
interface fb_port_arbiter_if #(
  parameter int COL_W  = 8,
  parameter int ROW_W  = 7,
  parameter int DATA_W = 16
);
  localparam int ADDR_W = ROW_W + COL_W;

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_gnt_o;
  logic              cpu_rvalid_o;
  logic [DATA_W-1:0] cpu_rdata_o;

  logic              fill_start_i;
  logic [COL_W-1:0]  fill_x0_i;
  logic [ROW_W-1:0]  fill_y0_i;
  logic [COL_W:0]    fill_w_i;
  logic [ROW_W:0]    fill_h_i;
  logic [DATA_W-1:0] fill_color_i;
  logic              fill_busy_o;
  logic              fill_done_o;

  logic              ena_o;
  logic              wea_o;
  logic [ADDR_W-1:0] addra_o;
  logic [DATA_W-1:0] dina_o;
  logic [DATA_W-1:0] douta_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    input  fill_start_i, fill_x0_i, fill_y0_i, fill_w_i, fill_h_i, fill_color_i,
    output fill_busy_o, fill_done_o,
    output ena_o, wea_o, addra_o, dina_o,
    input  douta_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    output fill_start_i, fill_x0_i, fill_y0_i, fill_w_i, fill_h_i, fill_color_i,
    input  fill_busy_o, fill_done_o,
    input  ena_o, wea_o, addra_o, dina_o,
    output douta_i
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Framebuffer port-A arbiter: shares the BRAM write/read port between CPU
// single-cell accesses and a solid-colour rectangle fill engine, using
// alternating priority under contention so neither side starves.
module fb_port_arbiter #(
  parameter int COL_W  = 8,
  parameter int ROW_W  = 7,
  parameter int DATA_W = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  fb_port_arbiter_if.slave bus,
  output logic [1:0] fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [COL_W-1:0]  x0_q, x_end_q, col_q;
  logic [ROW_W-1:0]  y_end_q, row_q;
  logic [DATA_W-1:0] color_q;
  logic              busy_q, done_q;
  logic              last_cpu_q;
  logic              rvalid_q;

  logic              fill_pending;
  logic              cpu_gnt, fill_gnt;
  logic [COL_W:0]    x_sum;
  logic [ROW_W:0]    y_sum;
  logic [COL_W-1:0]  x_end_d;
  logic [ROW_W-1:0]  y_end_d;
  logic              zero_size;

  assign fill_pending = (state_q == S_FILL);

  // Clipped rectangle extents; a carry out of the narrow sum means the
  // rectangle runs past the last column/row, so clamp rather than wrap.
  always_comb begin
    x_sum     = {1'b0, bus.fill_x0_i} + bus.fill_w_i - {{COL_W{1'b0}}, 1'b1};
    y_sum     = {1'b0, bus.fill_y0_i} + bus.fill_h_i - {{ROW_W{1'b0}}, 1'b1};
    x_end_d   = x_sum[COL_W] ? {COL_W{1'b1}} : x_sum[COL_W-1:0];
    y_end_d   = y_sum[ROW_W] ? {ROW_W{1'b1}} : y_sum[ROW_W-1:0];
    zero_size = (bus.fill_w_i == '0) || (bus.fill_h_i == '0);
  end

  // Per-cycle grant; under contention the side not served last time wins.
  // Grants are held off while reset is asserted so port A goes quiet at once.
  always_comb begin
    cpu_gnt  = 1'b0;
    fill_gnt = 1'b0;
    if (rst_n_i) begin
      if (bus.cpu_req_i && fill_pending) begin
        if (last_cpu_q) fill_gnt = 1'b1;
        else            cpu_gnt  = 1'b1;
      end else if (bus.cpu_req_i) begin
        cpu_gnt = 1'b1;
      end else if (fill_pending) begin
        fill_gnt = 1'b1;
      end
    end
  end

  // Port A mux: the granted requester owns the pins, otherwise all zero.
  always_comb begin
    bus.cpu_gnt_o = cpu_gnt;
    bus.ena_o     = cpu_gnt | fill_gnt;
    bus.wea_o     = 1'b0;
    bus.addra_o   = '0;
    bus.dina_o    = '0;
    if (cpu_gnt) begin
      bus.wea_o   = bus.cpu_we_i;
      bus.addra_o = bus.cpu_addr_i;
      bus.dina_o  = bus.cpu_wdata_i;
    end else if (fill_gnt) begin
      bus.wea_o   = 1'b1;
      bus.addra_o = {row_q, col_q};
      bus.dina_o  = color_q;
    end
  end

  // Fill engine FSM with raster walk and registered busy/done flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.fill_start_i) begin
            x0_q    <= bus.fill_x0_i;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            col_q   <= bus.fill_x0_i;
            row_q   <= bus.fill_y0_i;
            color_q <= bus.fill_color_i;
            busy_q  <= 1'b1;
            if (zero_size) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (fill_gnt) begin
            if (col_q == x_end_q) begin
              col_q <= x0_q;
              if (row_q == y_end_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                row_q <= row_q + {{(ROW_W-1){1'b0}}, 1'b1};
              end
            end else begin
              col_q <= col_q + {{(COL_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Priority memory and CPU read-return tracking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_cpu_q <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      last_cpu_q <= cpu_gnt;
      rvalid_q   <= cpu_gnt & ~bus.cpu_we_i;
    end
  end

  assign bus.cpu_rvalid_o = rvalid_q;
  assign bus.cpu_rdata_o  = rvalid_q ? bus.douta_i : '0;
  assign bus.fill_busy_o  = busy_q;
  assign bus.fill_done_o  = done_q;
  assign fsm_state_o      = state_q;

endmodule
